// File: rtl/rtl_top_pkg.sv
// Shared widths and the output-FIFO entry layout for the 2x2 downscaler.
package rtl_top_pkg;

  localparam int PIX_W = 8;

  function automatic int sum1_w(input int dw);
    return dw + 1;
  endfunction

  function automatic int sum2_w(input int dw);
    return dw + 2;
  endfunction

  // Output FIFO entry; total width is sum2_w(PIX_W).
  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             tlast;
    logic             tuser;
  } fifo2_entry_t;

endpackage

// File: rtl/rtl_top_fifo_sync.sv
// Synchronous first-word-fall-through FIFO: array storage with a registered
// read into an output stage, plus a bypass so a push into an empty FIFO shows next cycle.
module fifo_sync #(
  parameter int W       = 8,
  parameter int A_WIDTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << A_WIDTH;

  logic [W-1:0]       mem [DEPTH];
  logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [A_WIDTH:0]   mem_cnt_q, mem_cnt_d;
  logic               out_vld_q, out_vld_d;
  logic [W-1:0]       dout_q;
  logic [A_WIDTH+1:0] total;
  logic               do_push, do_pop, out_free, mem_rd, mem_wr, load_bypass;

  assign total = {1'b0, mem_cnt_q} + (A_WIDTH+2)'(out_vld_q);
  assign full  = (total == (A_WIDTH+2)'(DEPTH));
  assign empty = !out_vld_q;
  assign dout  = dout_q;

  always_comb begin
    do_push     = push & !full;
    do_pop      = pop & out_vld_q;
    out_free    = !out_vld_q | do_pop;
    mem_rd      = out_free & (mem_cnt_q != '0);
    load_bypass = out_free & (mem_cnt_q == '0) & do_push;
    mem_wr      = do_push & !load_bypass;
    wr_ptr_d    = wr_ptr_q + A_WIDTH'(mem_wr);
    rd_ptr_d    = rd_ptr_q + A_WIDTH'(mem_rd);
    mem_cnt_d   = mem_cnt_q + (A_WIDTH+1)'(mem_wr) - (A_WIDTH+1)'(mem_rd);
    out_vld_d   = out_free ? (mem_rd | load_bypass) : out_vld_q;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      mem_cnt_d = '0;
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_cnt_q <= '0;
      out_vld_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_cnt_q <= mem_cnt_d;
      out_vld_q <= out_vld_d;
    end
  end

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_wr && !flush) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (!flush) begin
      if (mem_rd) dout_q <= mem[rd_ptr_q];
      else if (load_bypass) dout_q <= din;
    end
  end

endmodule

// File: rtl/rtl_top.sv
// Streaming 2x2 averaging downscaler: even lines store pair sums in a line FIFO,
// odd lines combine them with their own pairs and emit through a small output FIFO.
module rtl_top
  import rtl_top_pkg::*;
#(
  parameter int D_WIDTH       = PIX_W,
  parameter int FIFO1_A_WIDTH = 8,
  parameter int FIFO2_A_WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] up_data,
  input  logic               up_valid,
  input  logic               up_tlast,
  input  logic               up_tuser,
  output logic               up_ready,
  output logic [D_WIDTH-1:0] down_data,
  output logic               down_valid,
  output logic               down_tlast,
  output logic               down_tuser,
  input  logic               down_ready
);

  localparam int S1_W = sum1_w(D_WIDTH);
  localparam int S2_W = sum2_w(D_WIDTH);

  logic               odd_line_q, odd_line_d;
  logic               pair_ph_q, pair_ph_d;
  logic               sof_q, sof_d;
  logic [D_WIDTH-1:0] hold_q, hold_d;

  logic               accept, eff_odd, eff_ph;
  logic               f1_push, f1_pop, f1_full, f1_empty, f1_flush;
  logic [S1_W-1:0]    f1_din, f1_dout;
  logic               f2_push, f2_full, f2_empty;
  fifo2_entry_t       f2_din, f2_dout;
  logic [S2_W-1:0]    sum2;

  // A frame-start pixel never pushes either FIFO, so it may always enter to resync.
  assign up_ready = up_tuser | (odd_line_q ? !f2_full : !f1_full);

  always_comb begin
    accept   = up_valid & up_ready;
    eff_odd  = odd_line_q & !up_tuser;
    eff_ph   = pair_ph_q & !up_tuser;
    f1_din   = S1_W'(hold_q) + S1_W'(up_data);
    sum2     = S2_W'(f1_dout) + S2_W'(hold_q) + S2_W'(up_data);
    f1_flush = accept & up_tuser;
    f1_push  = accept & eff_ph & !eff_odd;
    f1_pop   = accept & eff_ph & eff_odd & !f1_empty;
    f2_push  = f1_pop;
    f2_din.data  = sum2[S2_W-1:2];
    f2_din.tlast = up_tlast;
    f2_din.tuser = sof_q;

    hold_d     = hold_q;
    pair_ph_d  = pair_ph_q;
    odd_line_d = odd_line_q;
    sof_d      = sof_q;
    if (accept) begin
      hold_d     = eff_ph ? hold_q : up_data;
      pair_ph_d  = up_tlast ? 1'b0 : !eff_ph;
      odd_line_d = eff_odd ^ up_tlast;
      sof_d      = up_tuser | (sof_q & !f2_push);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      odd_line_q <= 1'b0;
      pair_ph_q  <= 1'b0;
      sof_q      <= 1'b0;
      hold_q     <= '0;
    end else begin
      odd_line_q <= odd_line_d;
      pair_ph_q  <= pair_ph_d;
      sof_q      <= sof_d;
      hold_q     <= hold_d;
    end
  end

  fifo_sync #(.W(S1_W), .A_WIDTH(FIFO1_A_WIDTH)) u_fifo1 (
    .clk   (clk),
    .rst_n (rst),
    .flush (f1_flush),
    .push  (f1_push),
    .din   (f1_din),
    .pop   (f1_pop),
    .dout  (f1_dout),
    .full  (f1_full),
    .empty (f1_empty)
  );

  fifo_sync #(.W(S2_W), .A_WIDTH(FIFO2_A_WIDTH)) u_fifo2 (
    .clk   (clk),
    .rst_n (rst),
    .flush (1'b0),
    .push  (f2_push),
    .din   (f2_din),
    .pop   (down_ready),
    .dout  (f2_dout),
    .full  (f2_full),
    .empty (f2_empty)
  );

  assign down_valid = !f2_empty;
  assign down_data  = f2_dout.data;
  assign down_tlast = f2_dout.tlast;
  assign down_tuser = f2_dout.tuser;

endmodule

// File: tb/tb_rtl_top.sv
// Directed self-checking bench for the 2x2 downscaler.
module tb_rtl_top;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] up_data;
  logic       up_valid, up_tlast, up_tuser, up_ready;
  logic [7:0] down_data;
  logic       down_valid, down_tlast, down_tuser, down_ready;

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;

  logic [7:0] oq_d[$];
  logic       oq_l[$];
  logic       oq_u[$];

  always #5 clk = ~clk;

  rtl_top #(.D_WIDTH(8), .FIFO1_A_WIDTH(8), .FIFO2_A_WIDTH(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_data    (up_data),
    .up_valid   (up_valid),
    .up_tlast   (up_tlast),
    .up_tuser   (up_tuser),
    .up_ready   (up_ready),
    .down_data  (down_data),
    .down_valid (down_valid),
    .down_tlast (down_tlast),
    .down_tuser (down_tuser),
    .down_ready (down_ready)
  );

  // Output monitor: records each transfer that the next rising edge will complete.
  always begin
    @(negedge clk);
    #2;
    if (rst && down_valid && down_ready) begin
      oq_d.push_back(down_data);
      oq_l.push_back(down_tlast);
      oq_u.push_back(down_tuser);
      $display("out #%0d data=%0d tlast=%0b tuser=%0b", oq_d.size() - 1, down_data, down_tlast, down_tuser);
    end
  end

  function automatic void clear_q();
    oq_d.delete();
    oq_l.delete();
    oq_u.delete();
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_px(input logic [7:0] d, input logic last, input logic user);
    int n;
    up_data  = d;
    up_tlast = last;
    up_tuser = user;
    up_valid = 1'b1;
    #1;
    if (!up_ready) stall_cnt++;
    n = 0;
    while (!up_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!up_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout up_ready=%0b required 1 (data %0d)", up_ready, d);
    end
    @(posedge clk);
    @(negedge clk);
    up_valid = 1'b0;
    up_tlast = 1'b0;
    up_tuser = 1'b0;
  endtask

  task automatic send4(input logic [7:0] a, b, c, d, input logic user);
    send_px(a, 1'b0, user);
    send_px(b, 1'b0, 1'b0);
    send_px(c, 1'b0, 1'b0);
    send_px(d, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    up_valid = 1'b0; up_tlast = 1'b0; up_tuser = 1'b0; up_data = 8'd0;
    down_ready = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", down_valid); end
    checks++; if (down_data !== 8'd0) begin errors++; $display("FAIL reset_data got %0d exp 0", down_data); end
    checks++; if (down_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %0b exp 0", down_tlast); end
    checks++; if (down_tuser !== 1'b0) begin errors++; $display("FAIL reset_tuser got %0b exp 0", down_tuser); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL reset_up_ready got %0b exp 1", up_ready); end
  endtask

  task automatic test_basic();
    clear_q();
    down_ready = 1'b1;
    send4(8'd10, 8'd20, 8'd30, 8'd40, 1'b1);
    send_px(8'd30, 1'b0, 1'b0);
    checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0b exp 0", down_valid); end
    send_px(8'd40, 1'b0, 1'b0);
    checks++; if (down_valid !== 1'b1) begin errors++; $display("FAIL basic_out0_valid got %0b exp 1", down_valid); end
    checks++; if (down_data !== 8'd25) begin errors++; $display("FAIL basic_out0_data got %0d exp 25", down_data); end
    checks++; if (down_tuser !== 1'b1) begin errors++; $display("FAIL basic_out0_tuser got %0b exp 1", down_tuser); end
    checks++; if (down_tlast !== 1'b0) begin errors++; $display("FAIL basic_out0_tlast got %0b exp 0", down_tlast); end
    send_px(8'd50, 1'b0, 1'b0);
    send_px(8'd60, 1'b1, 1'b0);
    checks++; if (down_valid !== 1'b1) begin errors++; $display("FAIL basic_out1_valid got %0b exp 1", down_valid); end
    checks++; if (down_data !== 8'd45) begin errors++; $display("FAIL basic_out1_data got %0d exp 45", down_data); end
    checks++; if (down_tuser !== 1'b0) begin errors++; $display("FAIL basic_out1_tuser got %0b exp 0", down_tuser); end
    checks++; if (down_tlast !== 1'b1) begin errors++; $display("FAIL basic_out1_tlast got %0b exp 1", down_tlast); end
    repeat (4) @(negedge clk);
    checks++; if (oq_d.size() != 2) begin errors++; $display("FAIL basic_count got %0d exp 2", oq_d.size()); end
  endtask

  task automatic test_trunc_max();
    logic [7:0] exp_d [2];
    exp_d = '{8'd2, 8'd255};
    clear_q();
    down_ready = 1'b1;
    send_px(8'd1, 1'b0, 1'b1);
    send_px(8'd2, 1'b1, 1'b0);
    send_px(8'd3, 1'b0, 1'b0);
    send_px(8'd4, 1'b1, 1'b0);
    send_px(8'd255, 1'b0, 1'b1);
    send_px(8'd255, 1'b1, 1'b0);
    send_px(8'd255, 1'b0, 1'b0);
    send_px(8'd255, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    checks++; if (oq_d.size() != 2) begin errors++; $display("FAIL trunc_count got %0d exp 2", oq_d.size()); end
    for (int i = 0; i < 2; i++) begin
      if (i < oq_d.size()) begin
        checks++;
        if (oq_d[i] !== exp_d[i] || oq_l[i] !== 1'b1 || oq_u[i] !== 1'b1) begin
          errors++;
          $display("FAIL trunc_out%0d got %0d/l%0b/u%0b exp %0d/l1/u1", i, oq_d[i], oq_l[i], oq_u[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d [4];
    logic       exp_l [4];
    logic       exp_u [4];
    exp_d = '{8'd7, 8'd19, 8'd31, 8'd43};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
    exp_u = '{1'b1, 1'b0, 1'b0, 1'b0};
    clear_q();
    down_ready = 1'b0;
    send_px(8'd8, 1'b0, 1'b1);
    send_px(8'd16, 1'b0, 1'b0);
    send_px(8'd24, 1'b0, 1'b0);
    send_px(8'd32, 1'b0, 1'b0);
    send_px(8'd40, 1'b0, 1'b0);
    send_px(8'd48, 1'b0, 1'b0);
    send_px(8'd56, 1'b0, 1'b0);
    send_px(8'd64, 1'b1, 1'b0);
    send_px(8'd0, 1'b0, 1'b0);
    send_px(8'd4, 1'b0, 1'b0);
    send_px(8'd8, 1'b0, 1'b0);
    send_px(8'd12, 1'b0, 1'b0);
    up_data = 8'd16; up_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (up_ready !== 1'b0) begin errors++; $display("FAIL bp_up_ready cyc%0d got %0b exp 0", c, up_ready); end
      checks++;
      if (down_valid !== 1'b1 || down_data !== 8'd7 || down_tuser !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cyc%0d got v%0b/%0d/u%0b exp v1/7/u1", c, down_valid, down_data, down_tuser);
      end
      @(negedge clk);
    end
    up_valid = 1'b0;
    down_ready = 1'b1;
    send_px(8'd16, 1'b0, 1'b0);
    send_px(8'd20, 1'b0, 1'b0);
    send_px(8'd24, 1'b0, 1'b0);
    send_px(8'd28, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    checks++; if (oq_d.size() != 4) begin errors++; $display("FAIL bp_count got %0d exp 4", oq_d.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < oq_d.size()) begin
        checks++;
        if (oq_d[i] !== exp_d[i] || oq_l[i] !== exp_l[i] || oq_u[i] !== exp_u[i]) begin
          errors++;
          $display("FAIL bp_out%0d got %0d/l%0b/u%0b exp %0d/l%0b/u%0b", i, oq_d[i], oq_l[i], oq_u[i], exp_d[i], exp_l[i], exp_u[i]);
        end
      end
    end
  endtask

  task automatic test_max_width();
    int stalls0;
    int s;
    logic [7:0] p0;
    logic [7:0] p1;
    clear_q();
    down_ready = 1'b1;
    stalls0 = stall_cnt;
    for (int i = 0; i < 512; i++) begin
      p0 = 8'(i);
      send_px(p0, (i == 511), (i == 0));
    end
    for (int i = 0; i < 512; i++) begin
      p1 = 8'(i * 7);
      send_px(p1, (i == 511), 1'b0);
    end
    repeat (5) @(negedge clk);
    checks++; if (stall_cnt != stalls0) begin errors++; $display("FAIL maxw_stalls got %0d exp 0", stall_cnt - stalls0); end
    checks++; if (oq_d.size() != 256) begin errors++; $display("FAIL maxw_count got %0d exp 256", oq_d.size()); end
    for (int k = 0; k < 256; k++) begin
      if (k < oq_d.size()) begin
        s = ((2 * k) % 256) + ((2 * k + 1) % 256) + ((2 * k * 7) % 256) + (((2 * k + 1) * 7) % 256);
        s = s / 4;
        checks++;
        if (oq_d[k] !== 8'(s) || oq_l[k] !== (k == 255) || oq_u[k] !== (k == 0)) begin
          errors++;
          $display("FAIL maxw_out%0d got %0d/l%0b/u%0b exp %0d/l%0b/u%0b", k, oq_d[k], oq_l[k], oq_u[k], s, (k == 255), (k == 0));
        end
      end
    end
  endtask

  task automatic test_resync();
    logic [7:0] exp_d [3];
    logic       exp_l [3];
    logic       exp_u [3];
    exp_d = '{8'd25, 8'd53, 8'd57};
    exp_l = '{1'b0, 1'b0, 1'b1};
    exp_u = '{1'b1, 1'b1, 1'b0};
    clear_q();
    down_ready = 1'b1;
    send4(8'd10, 8'd20, 8'd30, 8'd40, 1'b1);
    send_px(8'd30, 1'b0, 1'b0);
    send_px(8'd40, 1'b0, 1'b0);
    send_px(8'd50, 1'b0, 1'b0);
    send4(8'd100, 8'd100, 8'd100, 8'd100, 1'b1);
    send4(8'd4, 8'd8, 8'd12, 8'd16, 1'b0);
    repeat (4) @(negedge clk);
    checks++; if (oq_d.size() != 3) begin errors++; $display("FAIL resync_count got %0d exp 3", oq_d.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < oq_d.size()) begin
        checks++;
        if (oq_d[i] !== exp_d[i] || oq_l[i] !== exp_l[i] || oq_u[i] !== exp_u[i]) begin
          errors++;
          $display("FAIL resync_out%0d got %0d/l%0b/u%0b exp %0d/l%0b/u%0b", i, oq_d[i], oq_l[i], oq_u[i], exp_d[i], exp_l[i], exp_u[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midline();
    clear_q();
    down_ready = 1'b0;
    send4(8'd10, 8'd20, 8'd30, 8'd40, 1'b1);
    send_px(8'd30, 1'b0, 1'b0);
    send_px(8'd40, 1'b0, 1'b0);
    send_px(8'd50, 1'b0, 1'b0);
    checks++; if (down_valid !== 1'b1 || down_data !== 8'd25) begin errors++; $display("FAIL rstmid_pre got v%0b/%0d exp v1/25", down_valid, down_data); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b exp 0", down_valid); end
    checks++; if (down_data !== 8'd0) begin errors++; $display("FAIL rstmid_data got %0d exp 0", down_data); end
    checks++; if (down_tlast !== 1'b0 || down_tuser !== 1'b0) begin errors++; $display("FAIL rstmid_tags got l%0b/u%0b exp l0/u0", down_tlast, down_tuser); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL rstmid_up_ready got %0b exp 1", up_ready); end
    checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale got %0b exp 0", down_valid); end
    clear_q();
    down_ready = 1'b1;
    send4(8'd10, 8'd20, 8'd30, 8'd40, 1'b1);
    send4(8'd30, 8'd40, 8'd50, 8'd60, 1'b0);
    repeat (4) @(negedge clk);
    checks++; if (oq_d.size() != 2) begin errors++; $display("FAIL rstmid_count got %0d exp 2", oq_d.size()); end
    if (oq_d.size() >= 2) begin
      checks++;
      if (oq_d[0] !== 8'd25 || oq_l[0] !== 1'b0 || oq_u[0] !== 1'b1) begin
        errors++; $display("FAIL rstmid_out0 got %0d/l%0b/u%0b exp 25/l0/u1", oq_d[0], oq_l[0], oq_u[0]);
      end
      checks++;
      if (oq_d[1] !== 8'd45 || oq_l[1] !== 1'b1 || oq_u[1] !== 1'b0) begin
        errors++; $display("FAIL rstmid_out1 got %0d/l%0b/u%0b exp 45/l1/u0", oq_d[1], oq_l[1], oq_u[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_trunc_max();
    test_backpressure();
    test_max_width();
    test_resync();
    test_reset_midline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
